branch_predictor_param: RTL

Parametrised successor to the core's fixed branch predictor. It provides a direct-mapped BTB with per-entry branch type and a pattern history table of saturating counters. The PHT index is selectable between bimodal and gshare (global history XOR PC). Fetch-stage lookup is combinational in the same cycle; execute-stage resolution updates state on the next clock edge.

---
 rtl/branch_predictor_param.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor_param.sv
// branch_predictor_param: direct-mapped BTB with per-entry branch type plus a
// PHT of saturating counters, indexed bimodally (MODE 0) or gshare (MODE 1).
// Lookup is combinational; execute-stage resolution updates state on the clock.
// Optional return address stack: define RAS_EN to enable it.
//
// Handshake note: there is no valid/ready pair here. fetchValid qualifies only
// RAS push/pop, and exBranch/exJump qualify one resolution per cycle (never both).
module branch_predictor_param #(
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int MODE      = 0,
  parameter int GHR_LEN   = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        fetchPc,
  input  logic               fetchValid,
  output logic               fetchHit,
  output logic [31:0]        fetchTarget,
  output logic [GHR_LEN-1:0] fetchGhr,
  input  logic               exBranch,
  input  logic               exJump,
  input  logic               exIsCall,
  input  logic               exIsRet,
  input  logic               exTaken,
  input  logic [31:0]        exPc,
  input  logic [31:0]        exTarget,
  input  logic [GHR_LEN-1:0] exGhr
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [1:0] T_COND = 2'd0;
  localparam logic [1:0] T_JUMP = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  // Counters start weakly not-taken; MSB set means predict taken.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  // Prediction state
  logic                btb_valid  [ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [1:0]          btb_type   [ENTRIES];
  logic [CTR_BITS-1:0] pht        [ENTRIES];
  logic [GHR_LEN-1:0]  ghr;

  // Lookup-side decode
  logic [IDX-1:0]   f_pidx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX-1:0]   f_pht_idx;
  logic [1:0]       f_type;
  logic             hit_btb;

  // Update-side decode
  logic [IDX-1:0]   ex_pidx;
  logic [TAG_W-1:0] ex_tag;
  logic [IDX-1:0]   ex_pht_idx;
  logic [1:0]       ex_type;
  logic [GHR_LEN:0] ghr_shift;

  logic [IDX-1:0] ghr_ext;
  logic [IDX-1:0] ex_ghr_ext;

  // Zero-extend the histories to index width before the gshare XOR.
  always_comb begin
    ghr_ext                   = '0;
    ghr_ext[GHR_LEN-1:0]      = ghr;
    ex_ghr_ext                = '0;
    ex_ghr_ext[GHR_LEN-1:0]   = exGhr;
  end

  assign f_pidx     = fetchPc[IDX+1:2];
  assign f_tag      = fetchPc[31:IDX+2];
  assign f_pht_idx  = (MODE == 1) ? (f_pidx ^ ghr_ext) : f_pidx;
  assign f_type     = btb_type[f_pidx];
  assign hit_btb    = btb_valid[f_pidx] && (btb_tag[f_pidx] == f_tag);

  assign ex_pidx    = exPc[IDX+1:2];
  assign ex_tag     = exPc[31:IDX+2];
  assign ex_pht_idx = (MODE == 1) ? (ex_pidx ^ ex_ghr_ext) : ex_pidx;
  assign ghr_shift  = {ghr, exTaken};

  // Unconditional types always redirect on a BTB hit; conditional ones ask the PHT.
  assign fetchHit = hit_btb && ((f_type != T_COND) || pht[f_pht_idx][CTR_BITS-1]);
  assign fetchGhr = ghr;

`ifdef RAS_EN
  localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [RP_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_cnt;
  logic [RP_W-1:0]  ras_next;
  logic [RP_W-1:0]  ras_prev;
  logic             ras_use;
  logic             ras_push;
  logic             ras_pop;
  logic             unused_sig;

  assign ras_next = (ras_top == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_top + RP_W'(1);
  assign ras_prev = (ras_top == '0) ? RP_W'(RAS_DEPTH - 1) : ras_top - RP_W'(1);
  // A RET hit with a non-empty stack predicts the stack top even while stalled.
  assign ras_use  = hit_btb && (f_type == T_RET) && (ras_cnt != '0);
  assign ras_push = fetchValid && fetchHit && (f_type == T_CALL);
  assign ras_pop  = fetchValid && ras_use;
  assign unused_sig = ^{exPc[1:0]};

  // Circular stack: push overwrites the oldest slot once full, count saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ras_top <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_push) begin
      ras_mem[ras_next] <= fetchPc + 32'd4;
      ras_top           <= ras_next;
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (ras_pop) begin
      ras_top <= ras_prev;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end
`else
  logic unused_sig;
  assign unused_sig = ^{fetchValid, exIsCall, exIsRet, fetchPc[1:0], exPc[1:0]};
`endif

  // Predicted target: BTB target on a hit (or stack top for returns), else zero.
  always_comb begin
    fetchTarget = '0;
    if (hit_btb) fetchTarget = btb_target[f_pidx];
`ifdef RAS_EN
    if (ras_use) fetchTarget = ras_mem[ras_top];
`endif
  end

  // Branch type recorded in the BTB for the resolving instruction.
  always_comb begin
    ex_type = T_COND;
    if (exJump) begin
`ifdef RAS_EN
      if (exIsCall)     ex_type = T_CALL;
      else if (exIsRet) ex_type = T_RET;
      else              ex_type = T_JUMP;
`else
      ex_type = T_JUMP;
`endif
    end
  end

  // Resolution update: PHT and GHR for branches, BTB fill for any taken transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_type[i]   <= T_COND;
        pht[i]        <= CTR_INIT;
      end
    end else begin
      if (exBranch) begin
        if (exTaken && (pht[ex_pht_idx] != CTR_MAX))
          pht[ex_pht_idx] <= pht[ex_pht_idx] + CTR_BITS'(1);
        else if (!exTaken && (pht[ex_pht_idx] != '0))
          pht[ex_pht_idx] <= pht[ex_pht_idx] - CTR_BITS'(1);
        ghr <= ghr_shift[GHR_LEN-1:0];
      end
      if ((exBranch || exJump) && exTaken) begin
        btb_valid[ex_pidx]  <= 1'b1;
        btb_tag[ex_pidx]    <= ex_tag;
        btb_target[ex_pidx] <= exTarget;
        btb_type[ex_pidx]   <= ex_type;
      end
    end
  end

endmodule
